// File: rtl/counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : counter_cmd_seq
// Purpose  : Command sequencer for an N-bit up/down counter. Commands
//            {op, data, len} are accepted over a valid/ready handshake into a
//            small FIFO. Each command is replayed as cycle-exact, registered
//            syn_clr / load / en / up / d control for the counter.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous reset, active low
//            abort      - synchronous flush (only with the macro below)
//            cmd_valid  - command presented
//            cmd_ready  - FIFO not full
//            cmd_op     - 0 NOP, 1 CLEAR, 2 LOAD, 3 UP, 4 DOWN, 5 PAUSE,
//                         6-7 illegal
//            cmd_data   - LOAD value
//            cmd_len    - cycle count for UP / DOWN / PAUSE
//            syn_clr, load, en, up, d - registered counter controls
//            cmd_done   - pulse on the final output cycle of each command
//            illegal    - pulse when an illegal op is executed
//            busy       - FIFO non-empty or sequencer active
// Config   : COUNTER_CMD_SEQ_ABORT_EN - adds the abort input
// Revision : 1.0 - initial release
// ============================================================================
module counter_cmd_seq #(
    parameter int N     = 8,
    parameter int LEN_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef COUNTER_CMD_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [N-1:0]     cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             syn_clr,
    output logic             load,
    output logic             en,
    output logic             up,
    output logic [N-1:0]     d,
    output logic             cmd_done,
    output logic             illegal,
    output logic             busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 3 + N + LEN_W;

    localparam logic [2:0] c_OP_NOP   = 3'd0;
    localparam logic [2:0] c_OP_CLEAR = 3'd1;
    localparam logic [2:0] c_OP_LOAD  = 3'd2;
    localparam logic [2:0] c_OP_UP    = 3'd3;
    localparam logic [2:0] c_OP_DOWN  = 3'd4;
    localparam logic [2:0] c_OP_PAUSE = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;

    logic               w_abort;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_last;

    logic [c_ENT_W-1:0] w_head;
    logic [2:0]         w_head_op;
    logic [N-1:0]       w_head_data;
    logic [LEN_W-1:0]   w_head_len;

    state_t             r_state;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_dec;

`ifdef COUNTER_CMD_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign cmd_ready = !w_full;

    // A push coinciding with an abort is dropped along with the flush.
    assign w_push = cmd_valid && !w_full && !w_abort;

    // The sequencer can take a new command whenever the current cycle is the
    // final cycle of the running command (or nothing is running). Popping on
    // that same edge is what keeps back-to-back commands bubble-free.
    assign w_last = (r_state == S_IDLE) || (r_state == S_SINGLE) ||
                    ((r_state == S_RUN) && (r_cnt == LEN_W'(1)));
    assign w_pop  = w_last && !w_empty && !w_abort;

    assign w_count_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_cnt_dec   = r_cnt - LEN_W'(1);

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_op   = w_head[c_ENT_W-1 -: 3];
    assign w_head_data = w_head[LEN_W +: N];
    assign w_head_len  = w_head[LEN_W-1:0];

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_data, cmd_len};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs. The outputs loaded on an edge
    // are the controls for the cycle that follows it, so decoding happens
    // at pop time and r_cnt counts the cycles still to be driven,
    // including the current one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            syn_clr  <= 1'b0;
            load     <= 1'b0;
            en       <= 1'b0;
            up       <= 1'b1;
            d        <= '0;
            cmd_done <= 1'b0;
            illegal  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            illegal  <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                syn_clr <= 1'b0;
                load    <= 1'b0;
                en      <= 1'b0;
                busy    <= 1'b0;
            end else if (w_pop) begin
                r_state <= S_SINGLE;
                r_cnt   <= '0;
                syn_clr <= 1'b0;
                load    <= 1'b0;
                en      <= 1'b0;
                busy    <= 1'b1;
                case (w_head_op)
                    c_OP_NOP: begin
                        cmd_done <= 1'b1;
                    end
                    c_OP_CLEAR: begin
                        syn_clr  <= 1'b1;
                        cmd_done <= 1'b1;
                    end
                    c_OP_LOAD: begin
                        load     <= 1'b1;
                        d        <= w_head_data;
                        cmd_done <= 1'b1;
                    end
                    c_OP_UP, c_OP_DOWN, c_OP_PAUSE: begin
                        if (w_head_len != '0) begin
                            r_state  <= S_RUN;
                            r_cnt    <= w_head_len;
                            en       <= (w_head_op != c_OP_PAUSE);
                            cmd_done <= (w_head_len == LEN_W'(1));
                            // Direction only changes for real counting ops.
                            if (w_head_op == c_OP_UP) begin
                                up <= 1'b1;
                            end else if (w_head_op == c_OP_DOWN) begin
                                up <= 1'b0;
                            end
                        end else begin
                            // Zero-length: a single idle cycle that still
                            // reports completion.
                            cmd_done <= 1'b1;
                        end
                    end
                    default: begin
                        cmd_done <= 1'b1;
                        illegal  <= 1'b1;
                    end
                endcase
            end else if (w_last) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                syn_clr <= 1'b0;
                load    <= 1'b0;
                en      <= 1'b0;
                busy    <= (w_count_nxt != '0);
            end else begin
                // Mid-RUN: controls hold, count down the remaining cycles.
                r_cnt    <= w_cnt_dec;
                cmd_done <= (w_cnt_dec == LEN_W'(1));
                busy     <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_cmd_seq
// Purpose  : Directed self-checking bench for counter_cmd_seq. A negedge
//            monitor keeps a per-cycle trace, event tallies and a model of
//            the downstream counter; directed scenarios compare against
//            hand-computed expectations.
// Config   : COUNTER_CMD_SEQ_ABORT_EN - enables the abort scenario
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_cmd_seq;

    localparam logic [2:0] c_NOP   = 3'd0;
    localparam logic [2:0] c_CLEAR = 3'd1;
    localparam logic [2:0] c_LOAD  = 3'd2;
    localparam logic [2:0] c_UP    = 3'd3;
    localparam logic [2:0] c_DOWN  = 3'd4;
    localparam logic [2:0] c_PAUSE = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_len;
    logic       syn_clr, load, en, up;
    logic [7:0] d;
    logic       cmd_done, illegal, busy;
`ifdef COUNTER_CMD_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    counter_cmd_seq #(.N(8), .LEN_W(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef COUNTER_CMD_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .syn_clr   (syn_clr),
        .load      (load),
        .en        (en),
        .up        (up),
        .d         (d),
        .cmd_done  (cmd_done),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor: trace codes 0 quiet, 1 clear, 2 load, 3 count up, 4 down
    // ------------------------------------------------------------------
    int         m_en = 0, m_done = 0, m_ill = 0, m_strobe = 0, m_multi = 0;
    logic [7:0] m_ctr = 8'h00;
    logic [7:0] trace_code [$];
    logic [7:0] trace_d    [$];
    logic [7:0] done_val   [$];

    always @(negedge clk) begin
        if (rst) begin
            if (syn_clr)      trace_code.push_back(8'd1);
            else if (load)    trace_code.push_back(8'd2);
            else if (en && up) trace_code.push_back(8'd3);
            else if (en)      trace_code.push_back(8'd4);
            else              trace_code.push_back(8'd0);
            trace_d.push_back(d);
            if ((int'(syn_clr) + int'(load) + int'(en)) > 1) m_multi++;
            if (syn_clr || load || en) m_strobe++;
            if (en) m_en++;
            if (illegal) m_ill++;
            // Counter register acts on the next rising edge.
            if (syn_clr)   m_ctr = 8'h00;
            else if (load) m_ctr = d;
            else if (en)   m_ctr = up ? m_ctr + 8'd1 : m_ctr - 8'd1;
            if (cmd_done) begin
                m_done++;
                done_val.push_back(m_ctr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] data, input logic [3:0] len);
        int g = 0;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        cmd_valid = 1'b1;
        while (!cmd_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int g = 0;
        while (busy && g < budget) begin
            @(negedge clk);
            g++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #1;
    endtask

    logic [2:0] seq_op   [7] = '{c_LOAD, c_UP, c_PAUSE, c_DOWN, c_CLEAR, c_LOAD, c_UP};
    logic [7:0] seq_data [7] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00};
    logic [3:0] seq_len  [7] = '{4'd0, 4'd3, 4'd2, 4'd2, 4'd0, 4'd0, 4'd2};
    logic [7:0] exp_code [12] = '{8'd2, 8'd3, 8'd3, 8'd3, 8'd0, 8'd0,
                                  8'd4, 8'd4, 8'd1, 8'd2, 8'd3, 8'd3};
    logic [7:0] exp_done [7] = '{8'hA5, 8'hA8, 8'hA8, 8'hA6, 8'h00, 8'h3C, 8'h3E};

    initial begin
        int base, first, b_en, b_done, b_ill, b_strobe, seen, g;

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'd0;
        cmd_len   = 4'd0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_syn_clr",   {31'd0, syn_clr},   32'd0);
        check("rst_load",      {31'd0, load},      32'd0);
        check("rst_en",        {31'd0, en},        32'd0);
        check("rst_up",        {31'd0, up},        32'd1);
        check("rst_d",         {24'd0, d},         32'd0);
        check("rst_cmd_done",  {31'd0, cmd_done},  32'd0);
        check("rst_illegal",   {31'd0, illegal},   32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // ---------------- full sequence ----------------
        base   = trace_code.size();
        b_en   = m_en;
        b_done = done_val.size();
        for (int i = 0; i < 7; i++) push(seq_op[i], seq_data[i], seq_len[i]);
        wait_idle(100);
        first = -1;
        for (int i = base; i < trace_code.size(); i++) begin
            if (first < 0 && trace_code[i] != 8'd0) first = i;
        end
        if (first < 0 || first + 12 >= trace_code.size()) begin
            check("seq_found", 32'd0, 32'd1);
        end else begin
            for (int k = 0; k < 12; k++)
                check($sformatf("seq_cycle%0d", k), {24'd0, trace_code[first + k]}, {24'd0, exp_code[k]});
            check("seq_d_a5",  {24'd0, trace_d[first]},     32'hA5);
            check("seq_d_3c",  {24'd0, trace_d[first + 9]}, 32'h3C);
            check("seq_tail",  {24'd0, trace_code[first + 12]}, 32'd0);
        end
        check("seq_en_cycles", m_en - b_en, 32'd7);
        check("seq_done_count", done_val.size() - b_done, 32'd7);
        for (int k = 0; k < 7; k++) begin
            if (b_done + k < done_val.size())
                check($sformatf("seq_ctr%0d", k), {24'd0, done_val[b_done + k]}, {24'd0, exp_done[k]});
        end

        // ---------------- backpressure ----------------
        b_en   = m_en;
        b_done = m_done;
        for (int i = 0; i < 5; i++) push(c_UP, 8'h00, 4'd15);
        check("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
        check("bp_busy",      {31'd0, busy},      32'd1);
        wait_idle(200);
        check("bp_en_cycles", m_en - b_en, 32'd75);
        check("bp_done",      m_done - b_done, 32'd5);

        // ---------------- UP with len 0 ----------------
        b_en = m_en; b_done = m_done; b_strobe = m_strobe;
        push(c_UP, 8'h00, 4'd0);
        wait_idle(20);
        check("len0_en",     m_en - b_en, 32'd0);
        check("len0_done",   m_done - b_done, 32'd1);
        check("len0_strobe", m_strobe - b_strobe, 32'd0);

        // ---------------- illegal op ----------------
        b_done = m_done; b_strobe = m_strobe; b_ill = m_ill;
        push(3'd7, 8'h55, 4'd3);
        wait_idle(20);
        check("ill_pulse",  m_ill - b_ill, 32'd1);
        check("ill_done",   m_done - b_done, 32'd1);
        check("ill_strobe", m_strobe - b_strobe, 32'd0);

        // ---------------- reset during run ----------------
        push(c_UP, 8'h00, 4'd10);
        push(c_UP, 8'h00, 4'd5);
        seen = 0;
        g    = 0;
        while (seen < 2 && g < 20) begin
            @(negedge clk);
            if (en) seen++;
            g++;
        end
        check("rr_second_en", seen, 32'd2);
        rst = 1'b0;
        #1;
        check("rr_en",        {31'd0, en},        32'd0);
        check("rr_busy",      {31'd0, busy},      32'd0);
        check("rr_up",        {31'd0, up},        32'd1);
        check("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        b_en = m_en; b_done = m_done;
        repeat (30) @(negedge clk);
        #1;
        check("rr_no_residual_en",   m_en - b_en, 32'd0);
        check("rr_no_residual_done", m_done - b_done, 32'd0);
        check("rr_idle",             {31'd0, busy}, 32'd0);

`ifdef COUNTER_CMD_SEQ_ABORT_EN
        // ---------------- abort ----------------
        b_done = m_done;
        push(c_DOWN, 8'h00, 4'd8);
        push(c_UP,   8'h00, 4'd3);
        push(c_LOAD, 8'h11, 4'd0);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("ab_en",    {31'd0, en},        32'd0);
        check("ab_busy",  {31'd0, busy},      32'd0);
        check("ab_ready", {31'd0, cmd_ready}, 32'd1);
        b_en = m_en;
        repeat (20) @(negedge clk);
        #1;
        check("ab_no_en",   m_en - b_en, 32'd0);
        check("ab_no_done", m_done - b_done, 32'd0);
        check("ab_idle",    {31'd0, busy}, 32'd0);
`endif

        check("one_strobe_max", m_multi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_cmd_seq.md
# counter_cmd_seq

Command sequencer directly upstream of the 8-bit up/down counter register. It accepts compact commands (clear, load, count up/down for N cycles, pause for N cycles) over a valid/ready handshake and buffers them in a small FIFO. It replays each command as cycle-exact `syn_clr`/`load`/`en`/`up`/`d` control, so the counter can be driven from a bus or CPU without per-cycle software timing.

## Interface
- `N`, default 8: data width; matches counter `d`.
- `LEN_W`, default 4: width of the repeat-count field.
- `DEPTH`, default 4: command FIFO depth; must be a power of two, at least 2.

Ports:
- `clk`  in  1: the single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0).
- `cmd_valid`  in  1: a command is presented.
- `cmd_ready`  out  1: the FIFO can accept a command; equals `!full`.
- `cmd_op`  in  3: 0 NOP, 1 CLEAR, 2 LOAD, 3 UP, 4 DOWN, 5 PAUSE, 6–7 illegal.
- `cmd_data`  in  N: load value; used by LOAD only.
- `cmd_len`  in  LEN_W: cycle count for UP, DOWN and PAUSE.
- `syn_clr`, `load`, `en`  out  1 each: counter controls, registered.
- `up`  out  1: counter direction, registered.
- `d`  out  N: counter load data, registered.
- `cmd_done`  out  1: one-cycle pulse on the final output cycle of each command.
- `illegal`  out  1: one-cycle pulse when an op of 6 or 7 is popped.
- `busy`  out  1: FIFO is non-empty or the sequencer is not in IDLE.

## Operation
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`. The FIFO stores {op, data, len}.
- The FSM has three states: IDLE, SINGLE and RUN.
- **IDLE:** if the FIFO is non-empty, pop one command and decode it.
  - CLEAR, LOAD, NOP and illegal ops go to SINGLE.
  - UP, DOWN and PAUSE with len≥1 go to RUN, with `cnt` set to len.
  - UP, DOWN and PAUSE with len=0 go to SINGLE with all controls low.
- **SINGLE:** lasts one cycle.
  - CLEAR drives `syn_clr`=1.
  - LOAD drives `load`=1 and `d`=data.
  - NOP and illegal ops drive all controls low. Illegal ops also pulse `illegal`.
  - `cmd_done`=1 in this cycle.
- **RUN:** lasts `cnt` cycles.
  - UP drives `en`=1, `up`=1. DOWN drives `en`=1, `up`=0. PAUSE drives `en`=0.
  - `cnt` decrements each cycle. `cmd_done`=1 on the cycle where `cnt`==1.
- **Command boundary:** on the last cycle of SINGLE or RUN, if the FIFO is non-empty the next command is popped in the same edge, so there is no bubble. Otherwise the FSM returns to IDLE.
- **Output hold rules:**
  - At most one of `syn_clr`, `load` and `en` is high in any cycle.
  - `up` holds its last driven value outside UP/DOWN.
  - `d` holds its last load value.
- **FIFO full:** `cmd_ready`=0. A push and a pop in the same edge are allowed when the FIFO is not full. The count stays at its current value.
- **FIFO empty:** no pop occurs; the FSM stays in IDLE with all strobes low.

## Timing
- **Reset values:** `syn_clr`=`load`=`en`=0, `up`=1, `d`=0, `cmd_done`=0, `illegal`=0, `busy`=0, `cmd_ready`=1. FIFO empty, state IDLE, `cnt`=0.
- **Latency:** a command accepted at edge k into an empty, idle block drives its outputs after edge k+1. The counter acts on edge k+2.
- **Output duration:** UP or DOWN with len=L produces exactly L consecutive `en` cycles, so the counter moves by exactly ±L (mod 2^N).
- **Reset mid-command:** outputs drop to their reset values immediately (asynchronous). The FIFO is flushed and the partial command is discarded.
- `busy` is registered and deasserts in the cycle after the final `cmd_done` when the FIFO is empty.

## Configuration
- `COUNTER_CMD_SEQ_ABORT_EN`
  - **Defined:** adds input port `abort` (1 bit, synchronous, active-high). On an edge with `abort`=1:
    - the FIFO is flushed;
    - the FSM goes to IDLE;
    - all strobes are low in the next cycle;
    - no `cmd_done` is issued for the aborted command;
    - a push in the same edge is dropped.
  - **Undefined:** the port does not exist; commands always run to completion.

## Test plan
- **Reset:** release `rst` → all outputs at their reset values; `cmd_ready`=1; `busy`=0.
- **Full sequence:** push LOAD 0xA5, UP 3, PAUSE 2, DOWN 2, CLEAR, LOAD 0x3C, UP 2, back-to-back. Required output, one cycle per entry, with no gaps:
  - `load` with `d`=0xA5;
  - 3× `en`/`up`=1;
  - 2 idle;
  - 2× `en`/`up`=0;
  - `syn_clr`;
  - `load` with `d`=0x3C;
  - 2× `en`/`up`=1.
  - A counter model then reads 0xA5→0xA8→0xA6→0x00→0x3C→0x3E. There are 7 `cmd_done` pulses.
- **Backpressure:** push 5 UP commands with len=15 and `DEPTH`=4 → `cmd_ready` drops after 4 entries are buffered (the first is popped). Nothing is lost and exactly 75 `en` cycles occur.
- **Edge cases:**
  - UP with len=0 → no `en`, one `cmd_done`.
  - op 7 → `illegal` pulse and `cmd_done`, with no strobe.
- **Reset during run:** assert `rst` during the 2nd cycle of UP 10 → `en`=0 immediately and `busy`=0. After release, no residual commands execute.
- **Abort (with `COUNTER_CMD_SEQ_ABORT_EN` defined):** `abort` during DOWN 8 with 2 commands queued → `en` low in the next cycle, FIFO empty, no `cmd_done` for any of them.
